// File: rtl/demux_pkg.sv
// Purpose: shared widths, FIFO entry layout and FSM encoding for the demux feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

  localparam int DATA_W  = 4;
  localparam int SEL_W   = 2;
  localparam int ENTRY_W = DATA_W + SEL_W;
  localparam int PTR_W   = 2;
  localparam int CNT_W   = 3;
  localparam int DWELL_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Destination sits in the upper bits so {in_dest, in_data} maps directly.
  typedef struct packed {
    logic [SEL_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/demux_fifo4.sv
// Purpose: 4-entry FIFO of (dest, data) pairs feeding the demux sequencer.
// Latency: a pushed entry is visible at o_head one edge after the push (no bypass).
// Backpressure: pushes are ignored while full, pops ignored while empty.
//
// Ports: clk/rst (async active-high); i_push + i_push_entry write at the tail;
// i_pop advances the head; o_head is the current head entry; o_full/o_empty/
// o_count report occupancy from registered state only.
module demux_fifo4
  import demux_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  entry_t           i_push_entry,
  input  logic             i_pop,
  output entry_t           o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  entry_t             r_mem [4];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux_feeder.sv
// Purpose: buffers (data, dest) words and presents each on the demux I/S inputs for DWELL cycles.
// Latency: word accepted at edge k is driven after edge k+1; next word follows back-to-back.
// Backpressure: in_ready = (count != DEPTH), from registered count only.
//
// Ports: clk, rst (async active-high); in_data/in_dest/in_valid/in_ready producer
// handshake; I_out/S_out drive the demux; busy flags a word on the outputs;
// count is the FIFO occupancy 0..4.
module demux_feeder
  import demux_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DWELL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] I_out,
  output logic [SEL_W-1:0]  S_out,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DWELL_W-1:0]  r_dwell;
  logic [DATA_W-1:0]   r_i_out;
  logic [SEL_W-1:0]    r_s_out;

  logic                w_push;
  logic                w_pop;
  logic                w_load;
  logic                w_dec;
  logic                w_clear;
  logic                w_full;
  logic                w_empty;
  entry_t              w_head;
  entry_t              w_push_entry;
  logic [CNT_W-1:0]    w_count;

  assign in_ready     = !w_full;
  assign w_push       = in_valid && !w_full;
  assign w_push_entry = '{dest: in_dest, data: in_data};

  demux_fifo4 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A pop always coincides with a load of the output registers; the FIFO
  // head is only read from registered state, so nothing bypasses the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_dwell != '0) begin
          w_dec = 1'b1;
        end else if (!w_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end else begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
      r_i_out <= '0;
      r_s_out <= '0;
    end else if (w_load) begin
      r_dwell <= DWELL_LOAD;
      r_i_out <= w_head.data;
      r_s_out <= w_head.dest;
    end else if (w_dec) begin
      r_dwell <= r_dwell - 1'b1;
    end else if (w_clear) begin
      // S_out keeps its last value so the demux select does not glitch.
      r_i_out <= '0;
    end
  end

  assign I_out = r_i_out;
  assign S_out = r_s_out;
  assign busy  = (r_state == ST_DRIVE);
  assign count = w_count;

endmodule

// File: tb/tb_demux_feeder.sv
module tb_demux_feeder;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic [1:0] in_dest;

  logic       v1, v2, v4;
  logic       rdy1, rdy2, rdy4;
  logic [3:0] i1, i2, i4;
  logic [1:0] s1, s2, s4;
  logic       b1, b2, b4;
  logic [2:0] c1, c2, c4;

  int n_tests = 0;
  int n_fail  = 0;

  demux_feeder #(.DEPTH(4), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
    .in_valid(v1), .in_ready(rdy1), .I_out(i1), .S_out(s1), .busy(b1), .count(c1)
  );
  demux_feeder #(.DEPTH(4), .DWELL(2)) u_d2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
    .in_valid(v2), .in_ready(rdy2), .I_out(i2), .S_out(s2), .busy(b2), .count(c2)
  );
  demux_feeder #(.DEPTH(4), .DWELL(4)) u_d4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest),
    .in_valid(v4), .in_ready(rdy4), .I_out(i4), .S_out(s4), .busy(b4), .count(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed stimulus tables.
  logic [3:0] b2b_data [4] = '{4'b0100, 4'b1010, 4'b0011, 4'b1110};
  logic [1:0] b2b_dest [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  // Occupancy after edges 0..6 with DWELL=4 and in_valid held high.
  int         full_cnt [7] = '{1, 1, 2, 3, 4, 3, 4};
  int         full_rdy [7] = '{1, 1, 1, 1, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_dest = '0; v1 = 0; v2 = 0; v4 = 0;
    #2;
    check("rst_I",     int'(i2),   0);
    check("rst_S",     int'(s2),   0);
    check("rst_busy",  int'(b2),   0);
    check("rst_count", int'(c2),   0);
    check("rst_ready", int'(rdy2), 1);
    rst = 1'b0;
    tick; tick;

    // Single word, DWELL=2: push at edge 0.
    in_data = 4'b1010; in_dest = 2'd1; v2 = 1;
    tick;
    v2 = 0;
    check("sw_cnt_e0",  int'(c2), 1);
    check("sw_busy_e0", int'(b2), 0);
    check("sw_I_e0",    int'(i2), 0);
    for (int e = 1; e <= 4; e++) begin
      tick;
      if (e <= 2) begin
        check("sw_I",    int'(i2), 10);
        check("sw_S",    int'(s2), 1);
        check("sw_busy", int'(b2), 1);
      end else begin
        check("sw_I_idle",    int'(i2), 0);
        check("sw_busy_idle", int'(b2), 0);
        check("sw_S_hold",    int'(s2), 1);
      end
    end

    // Back-to-back, DWELL=2: four words on consecutive edges.
    for (int c = 0; c <= 9; c++) begin
      if (c < 4) begin
        v2 = 1; in_data = b2b_data[c]; in_dest = b2b_dest[c];
      end else begin
        v2 = 0;
      end
      tick;
      check("b2b_ready", int'(rdy2), 1);
      if (c >= 1 && c <= 8) begin
        check("b2b_I",    int'(i2), int'(b2b_data[(c-1)/2]));
        check("b2b_S",    int'(s2), int'(b2b_dest[(c-1)/2]));
        check("b2b_busy", int'(b2), 1);
      end else begin
        check("b2b_I_idle",    int'(i2), 0);
        check("b2b_busy_idle", int'(b2), 0);
      end
    end

    // Full, DWELL=4: six words, in_valid held; word 5 refused at edge 5.
    for (int e = 0; e <= 26; e++) begin
      if (e <= 6) begin
        v4 = 1;
        in_data = 4'((e < 5 ? e : 5) + 1);
        in_dest = 2'(e < 5 ? e : 5);
      end else begin
        v4 = 0;
      end
      tick;
      if (e <= 6) begin
        check("full_count", int'(c4),   full_cnt[e]);
        check("full_ready", int'(rdy4), full_rdy[e]);
      end
      if (e == 9) check("full_count_e9", int'(c4), 3);
      if (e >= 1 && e <= 24) begin
        check("full_I",    int'(i4), (e - 1) / 4 + 1);
        check("full_S",    int'(s4), ((e - 1) / 4) % 4);
        check("full_busy", int'(b4), 1);
      end else if (e > 24) begin
        check("full_I_idle",    int'(i4), 0);
        check("full_busy_idle", int'(b4), 0);
        check("full_cnt_idle",  int'(c4), 0);
      end
    end

    // Pointer wrap, DWELL=1: ten words streamed one per cycle.
    for (int c = 0; c <= 11; c++) begin
      if (c < 10) begin
        v1 = 1; in_data = 4'(c + 5); in_dest = 2'(c % 4);
      end else begin
        v1 = 0;
      end
      tick;
      check("wrap_ready", int'(rdy1), 1);
      check("wrap_count", int'(c1), (c <= 9) ? 1 : 0);
      if (c >= 1 && c <= 10) begin
        check("wrap_I",    int'(i1), c - 1 + 5);
        check("wrap_S",    int'(s1), (c - 1) % 4);
        check("wrap_busy", int'(b1), 1);
      end else if (c == 11) begin
        check("wrap_I_idle",    int'(i1), 0);
        check("wrap_busy_idle", int'(b1), 0);
      end
    end

    // Reset mid-DRIVE with count=3 (DWELL=4).
    for (int e = 0; e <= 3; e++) begin
      v4 = 1; in_data = 4'(9 + e); in_dest = 2'(e);
      tick;
    end
    v4 = 0;
    check("pre_rst_count", int'(c4), 3);
    check("pre_rst_busy",  int'(b4), 1);
    check("pre_rst_I",     int'(i4), 9);
    #2;
    rst = 1'b1;
    #1;
    check("arst_I",     int'(i4),   0);
    check("arst_S",     int'(s4),   0);
    check("arst_busy",  int'(b4),   0);
    check("arst_count", int'(c4),   0);
    check("arst_ready", int'(rdy4), 1);
    #2;
    rst = 1'b0;
    in_data = 4'b0111; in_dest = 2'd2; v4 = 1;
    tick;
    v4 = 0;
    check("post_rst_count", int'(c4), 1);
    check("post_rst_busy0", int'(b4), 0);
    tick;
    check("post_rst_I",    int'(i4), 7);
    check("post_rst_S",    int'(s4), 2);
    check("post_rst_busy", int'(b4), 1);
    check("post_rst_cnt0", int'(c4), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_feeder.md
# demux_feeder

Sequencer directly upstream of the 4-bit 1-to-4 demultiplexer (`demux_18`). It accepts (data, destination) pairs over a valid/ready handshake and buffers them in a 4-entry FIFO. It presents one word at a time on the demux `I`/`S` inputs, holding each word for a programmable dwell period. When it has nothing to send it drives `I = 0`, so all four demux outputs read zero.

## Interface

Parameters:
- `DEPTH`, default 4. FIFO entries. Fixed at 4; the pointers are 2 bits wide.
- `DWELL`, default 2. Number of cycles each word is held on `I_out`/`S_out`. Legal range 1..255.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `in_data`: input, 4 bits. Word to deliver.
- `in_dest`: input, 2 bits. Destination channel: 0 = A, 1 = B, 2 = C, 3 = D.
- `in_valid`: input, 1 bit. Producer has a word.
- `in_ready`: output, 1 bit. FIFO can accept a word.
- `I_out`: output, 4 bits. Connects to demux `I`.
- `S_out`: output, 2 bits. Connects to demux `S`.
- `busy`: output, 1 bit. A word is currently being driven.
- `count`: output, 3 bits. FIFO occupancy, 0..4.

## Operation

- **Push:** occurs on a rising edge when `in_valid && in_ready`. `{in_dest, in_data}` is written at the write pointer, the write pointer increments mod 4, and `count` increments.
- **Ready:** `in_ready = (count != 4)`. It is combinational from registered `count` only and never depends on `in_valid`.
- **FSM states:**
  - IDLE: `busy = 0`, `I_out = 0`.
  - DRIVE: `busy = 1`.
- **IDLE → DRIVE:** taken when `count > 0`.
  - Pop the head entry into the `I_out`/`S_out` registers.
  - Load the dwell counter with `DWELL - 1`.
- **In DRIVE:**
  - If the dwell counter is not 0, decrement it.
  - If it is 0 and `count > 0`, pop the next entry, reload the counter, and stay in DRIVE. Words go back-to-back with no gap cycle.
  - If it is 0 and `count == 0`, set `I_out` to 0, hold `S_out` at its last value, and go to IDLE.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Full FIFO:** a push is refused whenever `count == 4` at the edge, even if a pop happens in the same cycle.
- **Empty FIFO:** a push into an empty FIFO is never bypassed straight to the output. The word must be in the FIFO before it can be popped.
- **Pointer wrap:** pointers wrap 3 → 0 without any other effect.
- **Ordering:** words are delivered in strict FIFO order, independent of destination.

## Timing

- **Reset values** (asserted asynchronously, immediately on `rst`):
  - `I_out = 0`, `S_out = 0`, `busy = 0`, `count = 0`, `in_ready = 1`.
  - Pointers = 0, dwell counter = 0, state = IDLE.
- **Reset mid-operation:** discards all FIFO contents and the word being driven. Operation resumes cleanly on the first edge after `rst` deasserts.
- **Latency** for a word accepted at edge k into an empty, idle block:
  - `count = 1` after edge k.
  - The word appears on `I_out`/`S_out` after edge k+1, with `busy = 1`.
- **Hold and handover:** each word is held for exactly `DWELL` cycles.
  - The next word, if present, appears after edge k+1+`DWELL`.
  - Otherwise `I_out = 0` and `busy = 0` after that edge.
- **DWELL = 1:** one word per cycle. Sustained throughput with continuous input is then 1 word per cycle.

## Structure

- **Shared package `demux_pkg`:**
  - `DATA_W = 4`, `SEL_W = 2`.
  - FSM state encoding: `ST_IDLE = 1'b0`, `ST_DRIVE = 1'b1`.
  - FIFO entry width `ENTRY_W = DATA_W + SEL_W`.
- **Sub-module `demux_fifo4`:**
  - 4 × 6-bit storage, read and write pointers, 3-bit count.
  - Push/pop inputs, head output, full/empty flags.
- **Top level:** the FSM, dwell counter and output registers live in `demux_feeder`.

## Test plan

- **Reset:** assert `rst` mid-DRIVE with `count = 3`. Require `I_out = 0`, `busy = 0`, `count = 0` and `in_ready = 1` immediately, without waiting for a clock edge.
- **Single word:** `DWELL = 2`, push (`in_data = 4'b1010`, `in_dest = 1`) at edge 0.
  - `I_out = 1010`, `S_out = 01` during cycles 1–2.
  - `I_out = 0` and `busy = 0` from cycle 3.
- **Back-to-back:** `DWELL = 2`, push 0100→0, 1010→1, 0011→2, 1110→3 on consecutive edges.
  - The four words appear in order, each for exactly 2 cycles, with no gap.
  - `in_ready` stays 1 throughout.
- **Full:** `DWELL = 4`, hold `in_valid = 1` with 6 distinct words.
  - `in_ready` drops when `count = 4` and the 6th word waits.
  - No word is lost or duplicated, and the output order matches the push order.
- **Simultaneous push/pop at full:** `count = 4` at the dwell-expiry edge with `in_valid = 1`.
  - The push is refused and the pop occurs, so `count = 3` after the edge.
  - The push succeeds on the next edge, so `count` returns to 4.
- **Pointer wrap:** `DWELL = 1`, stream 10 words. The pointers wrap twice and all 10 words appear in order, one per cycle.
